pipe_stage_buf: RTL and testbench

//  Generic pipeline-boundary register with valid/ready handshake, hold and flush.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/stage_data_reg.sv | 22 ++
 rtl/pipe_stage_buf.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: state encoding, NOP payload, stage payload layout.
package pipe_pkg;

  localparam int unsigned PS_STATE_W = 2;
  localparam int unsigned INST_W     = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  // Stage occupancy state; the encoding doubles as the entry count.
  typedef enum logic [PS_STATE_W-1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } ps_state_e;

  // Typical IF/ID payload carried through the stage.
  typedef struct packed {
    logic [INST_W-1:0] pc_plus4;
    logic [INST_W-1:0] inst;
  } if_id_payload_t;

endpackage : pipe_pkg

// File: rtl/stage_data_reg.sv
// Enable register with asynchronous active-low reset to a fixed value.
module stage_data_reg #(
  parameter int unsigned           DATA_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // Load d when enabled, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : stage_data_reg

// File: rtl/pipe_stage_buf.sv
// Pipeline-boundary register with valid/ready handshake, hold, flush and an
// optional 2-entry skid buffer that keeps in_ready off the downstream ready path.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 64,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = DATA_WIDTH'(NOP_INST),
  parameter bit                    SKID         = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  ps_state_e             state_q;
  ps_state_e             state_d;
  logic                  not_full_q;
  logic                  in_fire;
  logic                  out_fire;
  logic                  main_en;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic                  skid_en;
  logic [DATA_WIDTH-1:0] skid_d;
  logic [DATA_WIDTH-1:0] skid_q;

  // Handshake: hold gates both sides; the skid variant takes ready from a flop.
  generate
    if (SKID) begin : g_ready_reg
      assign in_ready = not_full_q & ~hold;
    end else begin : g_ready_comb
      assign in_ready = ((state_q != PS_ONE) | out_ready) & ~hold;
    end
  endgenerate

  assign out_valid = (state_q != PS_EMPTY) & ~hold;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign occupancy = 2'(state_q);

  // State and registered not_full flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= PS_EMPTY;
      not_full_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      not_full_q <= (state_d != PS_FULL);
    end
  end

  // Next state and data-register loads; flush wins over every handshake and hold.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = main_q;
    skid_en = 1'b0;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
      main_en = 1'b1;
      main_d  = BUBBLE_VALUE;
      skid_en = 1'b1;
      skid_d  = BUBBLE_VALUE;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d = PS_ONE;
            main_en = 1'b1;
            main_d  = in_data;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
            main_d  = in_data;
          end else if (in_fire && SKID) begin
            state_d = PS_FULL;
            skid_en = 1'b1;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
            main_en = 1'b1;
            main_d  = BUBBLE_VALUE;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            state_d = PS_ONE;
            main_en = 1'b1;
            main_d  = skid_q;
            skid_en = 1'b1;
            skid_d  = BUBBLE_VALUE;
          end
        end
        default: begin
          state_d = PS_EMPTY;
        end
      endcase
    end
  end

  // Head entry, always presented on out_data.
  stage_data_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_VALUE(BUBBLE_VALUE)
  ) u_main (
    .clk  (clk),
    .rst_n(rst),
    .en   (main_en),
    .d    (main_d),
    .q    (main_q)
  );

  // Second entry exists only in the skid configuration.
  generate
    if (SKID) begin : g_skid
      stage_data_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_VALUE(BUBBLE_VALUE)
      ) u_skid (
        .clk  (clk),
        .rst_n(rst),
        .en   (skid_en),
        .d    (skid_d),
        .q    (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = BUBBLE_VALUE;
    end
  endgenerate

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: a skid instance driven from a vector table, plus hand sequences
// for mid-run reset and the single-entry configuration.
module tb_pipe_stage_buf;

  localparam int unsigned DW  = 64;
  localparam int unsigned DW0 = 32;

  localparam logic [DW-1:0] VA = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] VB = 64'hFEDC_BA98_7654_3210;
  localparam logic [DW-1:0] VC = 64'hCCCC_0000_CCCC_0000;
  localparam logic [DW-1:0] VD = 64'hDDDD_1111_DDDD_1111;
  localparam logic [DW-1:0] VE = 64'hEEEE_2222_EEEE_2222;

  logic          clk = 1'b0;
  logic          rst;

  logic          hold, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  logic           hold0, flush0, in_valid0, out_ready0;
  logic [DW0-1:0] in_data0;
  logic           in_ready0, out_valid0;
  logic [DW0-1:0] out_data0;
  logic [1:0]     occupancy0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          hold;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          exp_in_ready;
    logic          exp_out_valid;
    logic [DW-1:0] exp_out_data;
    logic [1:0]    exp_occ;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .DATA_WIDTH  (DW),
    .BUBBLE_VALUE('0),
    .SKID        (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  pipe_stage_buf #(
    .DATA_WIDTH  (DW0),
    .BUBBLE_VALUE('0),
    .SKID        (1'b0)
  ) dut0 (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold0),
    .flush    (flush0),
    .in_valid (in_valid0),
    .in_ready (in_ready0),
    .in_data  (in_data0),
    .out_valid(out_valid0),
    .out_ready(out_ready0),
    .out_data (out_data0),
    .occupancy(occupancy0)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic h, input logic f, input logic iv, input logic [DW-1:0] d,
                     input logic ordy, input logic e_ir, input logic e_ov,
                     input logic [DW-1:0] e_od, input logic [1:0] e_occ);
    vec_t v;
    v.hold = h; v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.exp_in_ready = e_ir; v.exp_out_valid = e_ov; v.exp_out_data = e_od; v.exp_occ = e_occ;
    vecs.push_back(v);
  endtask

  task automatic check_dut(input string tag, input logic e_ir, input logic e_ov,
                           input logic [DW-1:0] e_od, input logic [1:0] e_occ);
    chk({tag, ".in_ready"},  DW'(in_ready),  DW'(e_ir));
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(e_ov));
    chk({tag, ".out_data"},  out_data,       e_od);
    chk({tag, ".occupancy"}, DW'(occupancy), DW'(e_occ));
  endtask

  task automatic check_dut0(input string tag, input logic e_ir, input logic e_ov,
                            input logic [DW0-1:0] e_od, input logic [1:0] e_occ);
    chk({tag, ".in_ready"},  DW'(in_ready0),  DW'(e_ir));
    chk({tag, ".out_valid"}, DW'(out_valid0), DW'(e_ov));
    chk({tag, ".out_data"},  DW'(out_data0),  DW'(e_od));
    chk({tag, ".occupancy"}, DW'(occupancy0), DW'(e_occ));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    hold = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    hold0 = 1'b0; flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;

    // Cycle table: inputs for one cycle, outputs expected during that cycle.
    // Streaming 1..8 back-to-back.
    add(0, 0, 1, 64'd1, 1, 1, 0, '0, 2'd0);
    for (int k = 2; k <= 8; k++) add(0, 0, 1, DW'(k), 1, 1, 1, DW'(k - 1), 2'd1);
    add(0, 0, 0, '0, 1, 1, 1, 64'd8, 2'd1);
    add(0, 0, 0, '0, 0, 1, 0, '0, 2'd0);
    // Backpressure: A, B fill both entries, C refused, then A then B drain.
    add(0, 0, 1, VA, 0, 1, 0, '0, 2'd0);
    add(0, 0, 1, VB, 0, 1, 1, VA, 2'd1);
    add(0, 0, 1, VC, 0, 0, 1, VA, 2'd2);
    add(0, 0, 0, '0, 1, 0, 1, VA, 2'd2);
    add(0, 0, 0, '0, 1, 1, 1, VB, 2'd1);
    add(0, 0, 0, '0, 1, 1, 0, '0, 2'd0);
    // Flush at occupancy 2 with input offered and downstream ready.
    add(0, 0, 1, VA, 0, 1, 0, '0, 2'd0);
    add(0, 0, 1, VB, 0, 1, 1, VA, 2'd1);
    add(0, 1, 1, VC, 1, 0, 1, VA, 2'd2);
    add(0, 0, 0, '0, 1, 1, 0, '0, 2'd0);
    // Flush at occupancy 1 discards a simultaneous in_fire of C.
    add(0, 0, 1, VD, 0, 1, 0, '0, 2'd0);
    add(0, 1, 1, VC, 1, 1, 1, VD, 2'd1);
    add(0, 0, 0, '0, 1, 1, 0, '0, 2'd0);
    // Hold for 3 cycles with D held; D emitted once on release.
    add(0, 0, 1, VD, 0, 1, 0, '0, 2'd0);
    for (int k = 0; k < 3; k++) add(1, 0, 1, VE, 1, 0, 0, VD, 2'd1);
    add(0, 0, 0, '0, 1, 1, 1, VD, 2'd1);
    add(0, 0, 0, '0, 1, 1, 0, '0, 2'd0);
    // Flush overrides hold.
    add(0, 0, 1, VA, 0, 1, 0, '0, 2'd0);
    add(1, 1, 0, '0, 1, 0, 0, VA, 2'd1);
    add(0, 0, 0, '0, 0, 1, 0, '0, 2'd0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_dut("reset_held", 1'b1, 1'b0, '0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_dut("reset_released", 1'b1, 1'b0, '0, 2'd0);

    // Table run.
    foreach (vecs[i]) begin
      hold = vecs[i].hold; flush = vecs[i].flush; in_valid = vecs[i].in_valid;
      in_data = vecs[i].in_data; out_ready = vecs[i].out_ready;
      #1;
      check_dut($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_out_valid,
                vecs[i].exp_out_data, vecs[i].exp_occ);
      tick();
    end

    // Asynchronous reset with two entries held.
    hold = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = VA;
    tick();
    in_data = VB;
    tick();
    in_valid = 1'b0;
    #1;
    check_dut("pre_reset_full", 1'b0, 1'b1, VA, 2'd2);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst.out_valid", DW'(out_valid), '0);
    chk("midrst.out_data",  out_data,       '0);
    chk("midrst.occupancy", DW'(occupancy), '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_dut("midrst_release", 1'b1, 1'b0, '0, 2'd0);
    tick();

    // Single-entry configuration.
    in_valid0 = 1'b1; in_data0 = 32'h1111_AAAA; out_ready0 = 1'b0;
    #1;
    check_dut0("s0_empty", 1'b1, 1'b0, '0, 2'd0);
    tick();
    in_data0 = 32'h2222_BBBB;
    #1;
    check_dut0("s0_stalled", 1'b0, 1'b1, 32'h1111_AAAA, 2'd1);
    tick();
    check_dut0("s0_still", 1'b0, 1'b1, 32'h1111_AAAA, 2'd1);
    out_ready0 = 1'b1;
    #1;
    check_dut0("s0_replace", 1'b1, 1'b1, 32'h1111_AAAA, 2'd1);
    tick();
    in_valid0 = 1'b0;
    #1;
    check_dut0("s0_nobubble", 1'b1, 1'b1, 32'h2222_BBBB, 2'd1);
    tick();
    check_dut0("s0_drained", 1'b1, 1'b0, '0, 2'd0);
    hold0 = 1'b1;
    #1;
    chk("s0_hold.in_ready", DW'(in_ready0), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stage_buf
